// File: rtl/ddr_cmd_scheduler.sv
// Single-slot DDR4 command scheduler: arbitrates refresh, MRS and read/write requests
// under a closed-page policy, enforcing tRCD/tRC/tRFC/tMOD with internal down-counters.
module ddr_cmd_scheduler #(
  parameter int BANKS     = 8,
  parameter int ROW_W     = 15,
  parameter int COL_W     = 10,
  parameter int ADDR_W    = 17,
  parameter int MRS_WIDTH = 17,
  parameter int T_RCD     = 11,
  parameter int T_RC      = 39,
  parameter int T_RFC     = 208,
  parameter int T_MOD     = 24,
  localparam int BANK_W   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                 i_clock_t,
  input  logic                 i_reset,
  input  logic                 i_refresh_req,
  output logic                 o_refresh_ack,
  input  logic                 i_mrs_req,
  input  logic [MRS_WIDTH-1:0] i_mrs_cmd,
  output logic                 o_mrs_ack,
  input  logic                 i_rw_valid,
  output logic                 o_rw_ready,
  input  logic                 i_rw_write,
  input  logic [BANK_W-1:0]    i_rw_bank,
  input  logic [ROW_W-1:0]     i_rw_row,
  input  logic [COL_W-1:0]     i_rw_col,
  output logic                 o_cmd_valid,
  output logic [2:0]           o_cmd_type,
  output logic [BANK_W-1:0]    o_cmd_bank,
  output logic [ADDR_W-1:0]    o_cmd_addr,
  output logic                 o_rw_idle
);

  // state  | meaning
  // S_IDLE | arbitrating refresh > MRS > read/write; issues REF/MRS/ACT or NOP
  // S_RCD  | ACT issued; NOPs until tRCD elapses, then RD/WR with auto-precharge
  typedef enum logic [0:0] {S_IDLE, S_RCD} state_t;

  localparam int TW = 10;
  localparam logic [TW-1:0] RCD_LOAD = TW'(T_RCD - 1);
  localparam logic [TW-1:0] RC_LOAD  = TW'(T_RC - 1);
  localparam logic [TW-1:0] RFC_LOAD = TW'(T_RFC - 1);
  localparam logic [TW-1:0] MOD_LOAD = TW'(T_MOD - 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_REF = 3'd4;
  localparam logic [2:0] CMD_MRS = 3'd5;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_bank_timer [BANKS];
  logic [TW-1:0]       r_gtimer;
  logic [TW-1:0]       r_rcd_cnt;
  logic                r_wr;
  logic [BANK_W-1:0]   r_bank;
  logic [COL_W-1:0]    r_col;

  logic                r_cmd_valid;
  logic [2:0]          r_cmd_type;
  logic [BANK_W-1:0]   r_cmd_bank;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic                r_rw_ready;
  logic                r_refresh_ack;
  logic                r_mrs_ack;
  logic                r_rw_idle;

  logic                w_all_free;
  logic                w_bank_free;
  logic                w_act;
  logic                w_ref;
  logic                w_mrs;
  logic [2:0]          w_cmd_type;
  logic [BANK_W-1:0]   w_cmd_bank;
  logic [ADDR_W-1:0]   w_cmd_addr;

  always_comb begin
    w_all_free  = 1'b1;
    w_bank_free = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      if (r_bank_timer[b] != '0) w_all_free = 1'b0;
      if ((i_rw_bank == BANK_W'(b)) && (r_bank_timer[b] == '0)) w_bank_free = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_act       = 1'b0;
    w_ref       = 1'b0;
    w_mrs       = 1'b0;
    w_cmd_type  = CMD_NOP;
    w_cmd_bank  = '0;
    w_cmd_addr  = '0;
    case (r_state)
      S_IDLE: begin
        // A pending REF/MRS blocks new ACTs so the banks can drain.
        if (i_refresh_req) begin
          if (w_all_free && (r_gtimer == '0)) begin
            w_ref      = 1'b1;
            w_cmd_type = CMD_REF;
          end
        end else if (i_mrs_req) begin
          if (w_all_free && (r_gtimer == '0)) begin
            w_mrs      = 1'b1;
            w_cmd_type = CMD_MRS;
            w_cmd_addr = ADDR_W'(i_mrs_cmd);
          end
        end else if (i_rw_valid && w_bank_free && (r_gtimer == '0)) begin
          w_act       = 1'b1;
          w_cmd_type  = CMD_ACT;
          w_cmd_bank  = i_rw_bank;
          w_cmd_addr  = ADDR_W'(i_rw_row);
          w_state_nxt = S_RCD;
        end
      end
      S_RCD: begin
        if (r_rcd_cnt == '0) begin
          w_cmd_type      = r_wr ? CMD_WR : CMD_RD;
          w_cmd_bank      = r_bank;
          w_cmd_addr      = ADDR_W'(r_col);
          w_cmd_addr[10]  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock_t) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      for (int b = 0; b < BANKS; b++) r_bank_timer[b] <= '0;
      r_gtimer      <= '0;
      r_rcd_cnt     <= '0;
      r_wr          <= 1'b0;
      r_bank        <= '0;
      r_col         <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_type    <= CMD_NOP;
      r_cmd_bank    <= '0;
      r_cmd_addr    <= '0;
      r_rw_ready    <= 1'b0;
      r_refresh_ack <= 1'b0;
      r_mrs_ack     <= 1'b0;
      r_rw_idle     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      for (int b = 0; b < BANKS; b++) begin
        if (w_act && (i_rw_bank == BANK_W'(b))) r_bank_timer[b] <= RC_LOAD;
        else if (r_bank_timer[b] != '0)         r_bank_timer[b] <= r_bank_timer[b] - 1'b1;
      end
      if (w_ref)                 r_gtimer <= RFC_LOAD;
      else if (w_mrs)            r_gtimer <= MOD_LOAD;
      else if (r_gtimer != '0)   r_gtimer <= r_gtimer - 1'b1;
      if (w_act)                 r_rcd_cnt <= RCD_LOAD;
      else if (r_rcd_cnt != '0)  r_rcd_cnt <= r_rcd_cnt - 1'b1;
      if (w_act) begin
        r_wr   <= i_rw_write;
        r_bank <= i_rw_bank;
        r_col  <= i_rw_col;
      end
      r_cmd_valid   <= (w_cmd_type != CMD_NOP);
      r_cmd_type    <= w_cmd_type;
      r_cmd_bank    <= w_cmd_bank;
      r_cmd_addr    <= w_cmd_addr;
      r_rw_ready    <= w_act;
      r_refresh_ack <= w_ref;
      r_mrs_ack     <= w_mrs;
      // Reflects the state and timers seen on this edge, one cycle late.
      r_rw_idle     <= (r_state == S_IDLE) && w_all_free;
    end
  end

  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_type    = r_cmd_type;
  assign o_cmd_bank    = r_cmd_bank;
  assign o_cmd_addr    = r_cmd_addr;
  assign o_rw_ready    = r_rw_ready;
  assign o_refresh_ack = r_refresh_ack;
  assign o_mrs_ack     = r_mrs_ack;
  assign o_rw_idle     = r_rw_idle;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Scoreboard bench for ddr_cmd_scheduler: a timeline model predicts each command's issue
// cycle; a negedge monitor pops and compares every command the DUT presents.
module tb_ddr_cmd_scheduler;
  localparam int T_RCD = 11, T_RC = 39, T_RFC = 208, T_MOD = 24;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        refresh_req = 1'b0, mrs_req = 1'b0;
  logic [16:0] mrs_cmd = '0;
  logic        rw_valid = 1'b0, rw_write = 1'b0;
  logic [2:0]  rw_bank = '0;
  logic [14:0] rw_row = '0;
  logic [9:0]  rw_col = '0;
  logic        refresh_ack, mrs_ack, rw_ready, cmd_valid, rw_idle;
  logic [2:0]  cmd_type, cmd_bank;
  logic [16:0] cmd_addr;

  ddr_cmd_scheduler dut (
    .i_clock_t(clk), .i_reset(rst),
    .i_refresh_req(refresh_req), .o_refresh_ack(refresh_ack),
    .i_mrs_req(mrs_req), .i_mrs_cmd(mrs_cmd), .o_mrs_ack(mrs_ack),
    .i_rw_valid(rw_valid), .o_rw_ready(rw_ready), .i_rw_write(rw_write),
    .i_rw_bank(rw_bank), .i_rw_row(rw_row), .i_rw_col(rw_col),
    .o_cmd_valid(cmd_valid), .o_cmd_type(cmd_type), .o_cmd_bank(cmd_bank),
    .o_cmd_addr(cmd_addr), .o_rw_idle(rw_idle)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int typ; int bank; int addr; } exp_t;
  exp_t exp_q[$];
  int   act_list[$];
  int   bank_act[NB];
  int   last_ref, last_mrs, last_col;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ctrl_ready();
    int r;
    r = max2(last_ref + T_RFC, last_mrs + T_MOD);
    for (int b = 0; b < NB; b++) r = max2(r, bank_act[b] + T_RC);
    return r;
  endfunction

  function automatic int act_ready(input int b);
    int r;
    r = max2(bank_act[b] + T_RC, last_ref + T_RFC);
    r = max2(r, last_mrs + T_MOD);
    return max2(r, last_col + 1);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) bank_act[b] = -10000;
    last_ref = -10000; last_mrs = -10000; last_col = -10000;
    act_list.delete();
  endtask

  function automatic int exp_idle();
    int r;
    r = 1;
    foreach (act_list[i]) if (act_list[i] < cyc && cyc < act_list[i] + T_RC) r = 0;
    return r;
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          checks++; failures++;
          $display("FAIL missed_cmd cyc=%0d actual=none expected_type=%0d at cyc %0d", cyc, e.typ, e.cyc);
        end
        chk("valid_vs_type", int'(cmd_valid), int'(cmd_type != 3'd0));
        chk("ready_is_act", int'(rw_ready), int'(cmd_type == 3'd1));
        chk("refresh_ack_is_ref", int'(refresh_ack), int'(cmd_type == 3'd4));
        chk("mrs_ack_is_mrs", int'(mrs_ack), int'(cmd_type == 3'd5));
        if (rw_ready) chk("ready_without_valid", int'(rw_valid), 1);
        if (cmd_valid) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_cmd cyc=%0d actual_type=%0d expected=none", cyc, cmd_type);
          end else begin
            e = exp_q.pop_front();
            chk("cmd_cycle", cyc, e.cyc);
            chk("cmd_type", int'(cmd_type), e.typ);
            chk("cmd_bank", int'(cmd_bank), e.bank);
            chk("cmd_addr", int'(cmd_addr), e.addr);
          end
        end
        if (!rst) chk("rw_idle", int'(rw_idle), exp_idle());
      end
    end
  end

  task automatic issue_rw(input bit wr, input int b, input int row, input int col);
    int p, e, seen;
    exp_t x;
    p = cyc + 1;
    e = max2(p, act_ready(b));
    x = '{cyc: e, typ: 1, bank: b, addr: row};
    exp_q.push_back(x);
    x = '{cyc: e + T_RCD, typ: (wr ? 3 : 2), bank: b, addr: (col | 'h400)};
    exp_q.push_back(x);
    bank_act[b] = e; last_col = e + T_RCD; act_list.push_back(e);
    rw_valid = 1'b1; rw_write = wr; rw_bank = 3'(b); rw_row = 15'(row); rw_col = 10'(col);
    seen = -1;
    while (seen < 0 && cyc < e + 5) begin
      @(posedge clk); #1;
      if (rw_ready) seen = cyc;
    end
    chk("rw_ready_cycle", seen, e);
    @(posedge clk); #1;
    rw_valid = 1'b0;
  endtask

  task automatic issue_ctrl(input bit dref, input bit dmrs, input int mcmd);
    int p, e1, e2, got_r, got_m, lim;
    exp_t x;
    p = cyc + 1; e1 = -1; e2 = -1; got_r = -1; got_m = -1;
    if (dref) begin
      e1 = max2(p, ctrl_ready());
      x = '{cyc: e1, typ: 4, bank: 0, addr: 0};
      exp_q.push_back(x);
      last_ref = e1;
    end
    if (dmrs) begin
      e2 = max2(p, ctrl_ready());
      x = '{cyc: e2, typ: 5, bank: 0, addr: mcmd};
      exp_q.push_back(x);
      last_mrs = e2;
    end
    lim = max2(e1, e2) + 5;
    refresh_req = dref; mrs_req = dmrs; mrs_cmd = 17'(mcmd);
    while ((refresh_req || mrs_req) && cyc < lim) begin
      @(posedge clk); #1;
      if (refresh_req && refresh_ack) begin got_r = cyc; refresh_req = 1'b0; end
      if (mrs_req && mrs_ack) begin got_m = cyc; mrs_req = 1'b0; end
    end
    refresh_req = 1'b0; mrs_req = 1'b0;
    if (dref) chk("refresh_ack_cycle", got_r, e1);
    if (dmrs) chk("mrs_ack_cycle", got_m, e2);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, b, wait_n;
    model_reset();
    idle_cycles(3);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd_type", int'(cmd_type), 0);
    chk("rst_cmd_bank", int'(cmd_bank), 0);
    chk("rst_cmd_addr", int'(cmd_addr), 0);
    chk("rst_rw_ready", int'(rw_ready), 0);
    chk("rst_refresh_ack", int'(refresh_ack), 0);
    chk("rst_mrs_ack", int'(mrs_ack), 0);
    chk("rst_rw_idle", int'(rw_idle), 1);
    rst = 1'b0;
    mon_en = 1'b1;
    idle_cycles(6);

    issue_rw(1'b0, 2, 'h1234, 'h05);           // read bank 2
    idle_cycles(45);
    issue_rw(1'b1, 3, 'h0111, 'h3ff);          // back-to-back same bank
    issue_rw(1'b1, 3, 'h0222, 'h001);
    idle_cycles(40);
    issue_rw(1'b1, 0, 'h7fff, 'h010);          // different banks
    issue_rw(1'b1, 1, 'h0001, 'h020);
    idle_cycles(40);
    issue_rw(1'b0, 4, 'h0abc, 'h002);          // refresh raised 5 cycles after ACT
    idle_cycles(3);
    issue_ctrl(1'b1, 1'b0, 0);
    idle_cycles(10);
    issue_ctrl(1'b1, 1'b1, 'h0A54);            // REF and MRS together
    issue_rw(1'b0, 5, 'h0333, 'h003);

    issue_rw(1'b1, 6, 'h0444, 'h004);          // reset during tRCD
    idle_cycles(1);
    rst = 1'b1;
    void'(exp_q.pop_back());
    model_reset();
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(2);
    issue_rw(1'b0, 6, 'h0555, 'h006);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 99);
      b  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1) : $urandom_range(0, NB - 1);
      if (op < 70)      issue_rw(1'($urandom_range(0, 1)), b, $urandom & 'h7fff, $urandom & 'h3ff);
      else if (op < 82) issue_ctrl(1'b1, 1'b0, 0);
      else if (op < 94) issue_ctrl(1'b0, 1'b1, $urandom & 'h1ffff);
      else              issue_ctrl(1'b1, 1'b1, $urandom & 'h1ffff);
      idle_cycles($urandom_range(0, 3));
    end

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 400) begin idle_cycles(1); wait_n++; end
    idle_cycles(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
